chip8_mem_arbiter: RTL and testbench
====================================

// Module: chip8_mem_arbiter
// PURPOSE
//  Shares the single-port 4096x8 CHIP-8 RAM between two requesters: the CPU (port C) and the
//  ROM loader/debug port (port L). After reset it first runs an init sequencer that writes the
//  80-byte hex fontset into RAM. Only then does it grant requesters, one access per cycle,
//  round-robin on conflict. It sits between chip8_cpu, the loader and the RAM macro.
// PARAMETERS
//  ADDR_W     12      RAM address width
//  DATA_W     8       RAM data width
//  RAM_LAT    1       RAM read latency (cycles from ram_en to valid ram_rdata), 1..3
//  FONT_BASE  12'h050 first RAM address written by the font init sequencer
//  FONT_LEN   80      number of font bytes (16 glyphs x 5 rows)
// PORTS
//  clk        in   1       system clock, all logic rising-edge
//  reset      in   1       asynchronous, active-high reset
//  c_req      in   1       CPU access request; held with c_we/c_addr/c_wdata until c_gnt
//  c_we       in   1       1=write, 0=read
//  c_addr     in   ADDR_W  CPU address
//  c_wdata    in   DATA_W  CPU write data
//  c_gnt      out  1       combinational; request accepted this cycle
//  c_rvalid   out  1       one-cycle pulse, c_rdata valid
//  c_rdata    out  DATA_W  read data, held until next c_rvalid
//  l_req/l_we/l_addr/l_wdata/l_gnt/l_rvalid/l_rdata  same as C ports, loader side
//  ram_en     out  1       registered RAM enable
//  ram_we     out  1       registered RAM write enable
//  ram_addr   out  ADDR_W  registered RAM address
//  ram_wdata  out  DATA_W  registered RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid RAM_LAT cycles after ram_en&!ram_we
//  init_done  out  1       high once the fontset is written; stays high until reset
// BEHAVIOUR
//  Reset (async)
//   - ram_en=ram_we=0; ram_addr=ram_wdata=0; c_/l_rvalid=0; c_/l_rdata=0; init_done=0.
//   - Read-tag pipeline is cleared: in-flight reads are dropped, no rvalid after reset.
//   - RR pointer last=L, so the first conflict goes to C. Assertion mid-operation restarts INIT.
//  States
//   - INIT: k=0..FONT_LEN-1, one write per cycle: ram_addr=FONT_BASE+k, ram_wdata=font[k].
//     After k=FONT_LEN-1 is issued, go to RUN; init_done=1 from the next cycle.
//     c_gnt=l_gnt=0 throughout INIT.
//   - RUN: arbitration, below. There is no exit except reset.
//  Arbitration (RUN, combinational gnt)
//   - Only C requests -> c_gnt=1. Only L requests -> l_gnt=1.
//   - Both request -> grant the port not equal to last; last updates to the granted port.
//   - At most one gnt per cycle. No grant is allowed when no request is present.
//  Access timing (grant in cycle T)
//   - T+1: ram_en=1 with the granted port's we/addr/wdata registered; idle cycle -> ram_en=0.
//   - Reads: tag (port id) shifts through a RAM_LAT+1 deep pipe.
//     At T+1+RAM_LAT, ram_rdata is captured into that port's rdata and rvalid pulses at T+2+RAM_LAT.
//     Back-to-back reads are fully pipelined, one per cycle.
//   - Writes: no rvalid. A read after a write to the same address returns the new data,
//     because RAM order = grant order.
//  Boundary conditions
//   - Request withdrawn before gnt: legal, nothing issued.
//   - Both ports request every cycle: strict alternation C,L,C,L...
//   - Request held during INIT: waits; granted in the first RUN cycle.
//   - Addresses are used as-is (12-bit, no wrap logic). A write overlapping the font region is allowed.
// STRUCTURE
//  - Shared package chip8_pkg: CHIP8_ADDR_W=12, CHIP8_DATA_W=8, FONT_BASE, FONT_LEN,
//    port-id enum PORT_C=0/PORT_L=1.
//  - Sub-module chip8_font_rom: combinational 80x8 table, input idx[6:0], output byte.
//    Standard CHIP-8 glyphs 0..F; byte 0 = 8'hF0, byte 79 = 8'h80.
//  - This module: INIT/RUN FSM, font counter, RR arbiter, registered RAM stage, read-tag pipe.
// TESTING
//  - Reset, run with no requests -> exactly 80 writes, addr 0x050..0x09F, first data 8'hF0,
//    last data 8'h80; init_done rises at cycle 81; no gnt before.
//  - RAM_LAT=1, C read 0x200 (RAM holds 8'h12) at T -> c_gnt at T, ram_en at T+1,
//    c_rvalid with c_rdata=8'h12 at T+3; l_rvalid stays 0.
//  - C and L both request reads every cycle for 6 cycles -> grants C,L,C,L,C,L;
//    rvalids return in the same order with the correct data.
//  - L writes 8'hAB to 0x300, C reads 0x300 next cycle -> c_rdata=8'hAB.
//  - Assert reset 1 cycle after a C read grant -> no c_rvalid; INIT restarts at 0x050;
//    init_done=0 until 80 writes complete.
//  - C holds req during INIT -> c_gnt=0 until init_done; granted in the first RUN cycle.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory constants and types used by the RAM arbiter and its font table.
package chip8_pkg;

  localparam int CHIP8_ADDR_W = 12;
  localparam int CHIP8_DATA_W = 8;
  localparam logic [CHIP8_ADDR_W-1:0] FONT_BASE = 12'h050;
  localparam int FONT_LEN = 80;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_id_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Bundles both requester ports and the RAM macro port of the CHIP-8 memory arbiter.
interface chip8_mem_arbiter_if;
  import chip8_pkg::*;

  logic                    c_req;
  logic                    c_we;
  logic [CHIP8_ADDR_W-1:0] c_addr;
  logic [CHIP8_DATA_W-1:0] c_wdata;
  logic                    c_gnt;
  logic                    c_rvalid;
  logic [CHIP8_DATA_W-1:0] c_rdata;

  logic                    l_req;
  logic                    l_we;
  logic [CHIP8_ADDR_W-1:0] l_addr;
  logic [CHIP8_DATA_W-1:0] l_wdata;
  logic                    l_gnt;
  logic                    l_rvalid;
  logic [CHIP8_DATA_W-1:0] l_rdata;

  logic                    ram_en;
  logic                    ram_we;
  logic [CHIP8_ADDR_W-1:0] ram_addr;
  logic [CHIP8_DATA_W-1:0] ram_wdata;
  logic [CHIP8_DATA_W-1:0] ram_rdata;

  logic                    init_done;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output init_done
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  init_done
  );

endinterface

// File: rtl/chip8_font_rom.sv
// Combinational CHIP-8 hex fontset: glyphs 0..F, five rows each, 80 bytes total.
module chip8_font_rom (
  input  logic [6:0] i_idx,
  output logic [7:0] o_byte
);

  localparam logic [7:0] FONT_TABLE [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  always_comb begin
    o_byte = 8'h00;
    if (i_idx < 7'd80) begin
      o_byte = FONT_TABLE[i_idx];
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares the single-port CHIP-8 RAM between CPU and loader after writing the fontset;
// round-robin on conflict, registered RAM stage, read-tag pipe routes returning data.
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int                 ADDR_W       = CHIP8_ADDR_W,
  parameter int                 DATA_W       = CHIP8_DATA_W,
  parameter int                 RAM_LAT      = 1,
  parameter logic [ADDR_W-1:0]  FONT_BASE_AD = FONT_BASE,
  parameter int                 FONT_COUNT   = FONT_LEN
) (
  input  logic                clk,
  input  logic                reset,
  chip8_mem_arbiter_if.slave  bus
);

  arb_state_e        r_state, w_state_next;
  logic [6:0]        r_font_idx, w_font_idx_next;
  port_id_e          r_last, w_last_next;
  logic              w_c_gnt, w_l_gnt;
  logic [7:0]        w_font_byte;

  logic              r_ram_en, w_ram_en_next;
  logic              r_ram_we, w_ram_we_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_next;

  logic              w_tag_vld_in;
  logic              w_tag_port_in;
  logic [RAM_LAT:0]  r_tag_vld;
  logic [RAM_LAT:0]  r_tag_port;

  logic              r_c_rvalid, r_l_rvalid;
  logic [DATA_W-1:0] r_c_rdata, r_l_rdata;

  chip8_font_rom u_font_rom (
    .i_idx  (r_font_idx),
    .o_byte (w_font_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_font_idx  <= 7'd0;
      r_last      <= PORT_L;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_font_idx  <= w_font_idx_next;
      r_last      <= w_last_next;
      r_ram_en    <= w_ram_en_next;
      r_ram_we    <= w_ram_we_next;
      r_ram_addr  <= w_ram_addr_next;
      r_ram_wdata <= w_ram_wdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_font_idx_next  = r_font_idx;
    w_last_next      = r_last;
    w_c_gnt          = 1'b0;
    w_l_gnt          = 1'b0;
    w_ram_en_next    = 1'b0;
    w_ram_we_next    = 1'b0;
    w_ram_addr_next  = r_ram_addr;
    w_ram_wdata_next = r_ram_wdata;
    w_tag_vld_in     = 1'b0;
    w_tag_port_in    = PORT_C;

    case (r_state)
      ST_INIT: begin
        w_ram_en_next    = 1'b1;
        w_ram_we_next    = 1'b1;
        w_ram_addr_next  = FONT_BASE_AD + ADDR_W'(r_font_idx);
        w_ram_wdata_next = DATA_W'(w_font_byte);
        if (r_font_idx == 7'(FONT_COUNT - 1)) begin
          w_state_next    = ST_RUN;
          w_font_idx_next = 7'd0;
        end else begin
          w_font_idx_next = r_font_idx + 7'd1;
        end
      end
      ST_RUN: begin
        // On conflict the port that did not win last time goes first.
        if (bus.c_req && bus.l_req) begin
          w_c_gnt = (r_last == PORT_L);
          w_l_gnt = (r_last == PORT_C);
        end else begin
          w_c_gnt = bus.c_req;
          w_l_gnt = bus.l_req;
        end

        if (w_c_gnt) begin
          w_last_next      = PORT_C;
          w_ram_en_next    = 1'b1;
          w_ram_we_next    = bus.c_we;
          w_ram_addr_next  = bus.c_addr;
          w_ram_wdata_next = bus.c_wdata;
          w_tag_vld_in     = ~bus.c_we;
          w_tag_port_in    = PORT_C;
        end else if (w_l_gnt) begin
          w_last_next      = PORT_L;
          w_ram_en_next    = 1'b1;
          w_ram_we_next    = bus.l_we;
          w_ram_addr_next  = bus.l_addr;
          w_ram_wdata_next = bus.l_wdata;
          w_tag_vld_in     = ~bus.l_we;
          w_tag_port_in    = PORT_L;
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // Stage 0 lines up with ram_en; stage RAM_LAT lines up with valid ram_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld[0]  <= 1'b0;
      r_tag_port[0] <= 1'b0;
    end else begin
      r_tag_vld[0]  <= w_tag_vld_in;
      r_tag_port[0] <= w_tag_port_in;
    end
  end

  generate
    for (genvar gi = 1; gi <= RAM_LAT; gi++) begin : g_tag_pipe
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tag_vld[gi]  <= 1'b0;
          r_tag_port[gi] <= 1'b0;
        end else begin
          r_tag_vld[gi]  <= r_tag_vld[gi-1];
          r_tag_port[gi] <= r_tag_port[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_l_rdata  <= '0;
    end else begin
      r_c_rvalid <= r_tag_vld[RAM_LAT] && (r_tag_port[RAM_LAT] == PORT_C);
      r_l_rvalid <= r_tag_vld[RAM_LAT] && (r_tag_port[RAM_LAT] == PORT_L);
      if (r_tag_vld[RAM_LAT] && (r_tag_port[RAM_LAT] == PORT_C)) begin
        r_c_rdata <= bus.ram_rdata;
      end
      if (r_tag_vld[RAM_LAT] && (r_tag_port[RAM_LAT] == PORT_L)) begin
        r_l_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.c_gnt     = w_c_gnt;
  assign bus.l_gnt     = w_l_gnt;
  assign bus.c_rvalid  = r_c_rvalid;
  assign bus.l_rvalid  = r_l_rvalid;
  assign bus.c_rdata   = r_c_rdata;
  assign bus.l_rdata   = r_l_rdata;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.init_done = (r_state == ST_RUN);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a 1-cycle-latency RAM model behind it.
module tb_chip8_mem_arbiter;
  import chip8_pkg::*;

  localparam int RAM_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  chip8_mem_arbiter_if bus ();

  chip8_mem_arbiter #(.RAM_LAT(RAM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:4095];
  logic [7:0] ram_rdata_q = 8'h00;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_rdata_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_rdata_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts font writes until init_done; checks no grant and no rvalid appear meanwhile.
  task automatic run_init(input bit hold_c);
    int         writes = 0;
    int         edges  = 0;
    logic [11:0] first_addr = '0, last_addr = '0;
    logic [7:0]  first_data = '0, last_data = '0;
    bit         early_gnt = 1'b0;
    bit         seen_rv   = 1'b0;
    while (!bus.init_done && edges < 200) begin
      if (bus.c_gnt || bus.l_gnt) early_gnt = 1'b1;
      tick();
      edges++;
      if (bus.c_rvalid || bus.l_rvalid) seen_rv = 1'b1;
      if (bus.ram_en && bus.ram_we) begin
        if (writes == 0) begin
          first_addr = bus.ram_addr;
          first_data = bus.ram_wdata;
        end
        last_addr = bus.ram_addr;
        last_data = bus.ram_wdata;
        writes++;
      end
    end
    check_eq("init_done_edge", 32'(edges), 32'd80);
    check_eq("init_writes", 32'(writes), 32'd80);
    check_eq("init_first_addr", 32'(first_addr), 32'h050);
    check_eq("init_first_data", 32'(first_data), 32'hF0);
    check_eq("init_last_addr", 32'(last_addr), 32'h09F);
    check_eq("init_last_data", 32'(last_data), 32'h80);
    check_eq("init_no_gnt", 32'(early_gnt), 32'd0);
    check_eq("init_no_rvalid", 32'(seen_rv), 32'd0);
    check_eq("run_c_gnt", 32'(bus.c_gnt), 32'(hold_c));
  endtask

  int         c_idx, l_idx, rv_count;
  logic [7:0] exp_data_q[$];
  bit         exp_port_q[$];

  initial begin
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h12;
    for (int i = 0; i < 3; i++) begin
      mem[12'h210 + i] = 8'h30 + 8'(i);
      mem[12'h220 + i] = 8'h40 + 8'(i);
    end

    #3 reset = 1'b1;
    #1;
    check_eq("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check_eq("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check_eq("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    check_eq("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    check_eq("rst_c_rdata", 32'(bus.c_rdata), 32'd0);
    check_eq("rst_l_rdata", 32'(bus.l_rdata), 32'd0);
    check_eq("rst_init_done", 32'(bus.init_done), 32'd0);
    @(negedge clk) reset = 1'b0;

    run_init(1'b0);
    check_eq("run_init_done", 32'(bus.init_done), 32'd1);
    tick();
    check_eq("idle_ram_en", 32'(bus.ram_en), 32'd0);

    // Both ports read every cycle: expect C,L,C,L,C,L and in-order returns.
    bus.c_addr = 12'h210;
    bus.l_addr = 12'h220;
    c_idx = 0; l_idx = 0; rv_count = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.c_req = (cyc < 6);
      bus.l_req = (cyc < 6);
      #1;
      if (cyc < 6) begin
        check_eq("rr_c_gnt", 32'(bus.c_gnt), 32'((cyc % 2) == 0));
        check_eq("rr_l_gnt", 32'(bus.l_gnt), 32'((cyc % 2) == 1));
        if (bus.c_gnt) begin
          exp_port_q.push_back(1'b0);
          exp_data_q.push_back(8'h30 + 8'(c_idx));
          c_idx++;
        end else if (bus.l_gnt) begin
          exp_port_q.push_back(1'b1);
          exp_data_q.push_back(8'h40 + 8'(l_idx));
          l_idx++;
        end
      end
      tick();
      bus.c_addr = 12'h210 + 12'(c_idx);
      bus.l_addr = 12'h220 + 12'(l_idx);
      if (bus.c_rvalid || bus.l_rvalid) begin
        rv_count++;
        if (exp_port_q.size() == 0) begin
          check_eq("rr_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          check_eq("rr_rvalid_port", 32'(bus.l_rvalid), 32'(exp_port_q.pop_front()));
          check_eq("rr_rdata", bus.l_rvalid ? 32'(bus.l_rdata) : 32'(bus.c_rdata),
                   32'(exp_data_q.pop_front()));
        end
      end
    end
    check_eq("rr_rvalid_count", 32'(rv_count), 32'd6);

    // Single C read of 0x200: grant T, ram_en T+1, rvalid T+3.
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 12'h200;
    #1;
    check_eq("rd_c_gnt", 32'(bus.c_gnt), 32'd1);
    check_eq("rd_l_gnt", 32'(bus.l_gnt), 32'd0);
    tick();
    bus.c_req = 0;
    check_eq("rd_ram_en", 32'(bus.ram_en), 32'd1);
    check_eq("rd_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("rd_ram_addr", 32'(bus.ram_addr), 32'h200);
    tick();
    check_eq("rd_rvalid_t2", 32'(bus.c_rvalid), 32'd0);
    tick();
    check_eq("rd_rvalid_t3", 32'(bus.c_rvalid), 32'd1);
    check_eq("rd_rdata", 32'(bus.c_rdata), 32'h12);
    check_eq("rd_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    tick();
    check_eq("rd_rvalid_pulse", 32'(bus.c_rvalid), 32'd0);
    check_eq("rd_rdata_held", 32'(bus.c_rdata), 32'h12);

    // L writes 0xAB to 0x300, C reads it back the next cycle.
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 12'h300; bus.l_wdata = 8'hAB;
    #1;
    check_eq("wr_l_gnt", 32'(bus.l_gnt), 32'd1);
    tick();
    bus.l_req = 0; bus.l_we = 0;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 12'h300;
    #1;
    check_eq("wr_ram_we", 32'(bus.ram_we), 32'd1);
    check_eq("wrrd_c_gnt", 32'(bus.c_gnt), 32'd1);
    tick();
    bus.c_req = 0;
    tick();
    tick();
    check_eq("wrrd_rvalid", 32'(bus.c_rvalid), 32'd1);
    check_eq("wrrd_rdata", 32'(bus.c_rdata), 32'hAB);
    check_eq("wrrd_l_rvalid", 32'(bus.l_rvalid), 32'd0);

    // Reset one cycle after a C read grant, keep C requesting through INIT.
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 12'h200;
    #1;
    check_eq("mid_c_gnt", 32'(bus.c_gnt), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ram_en", 32'(bus.ram_en), 32'd0);
    check_eq("mid_rst_init_done", 32'(bus.init_done), 32'd0);
    check_eq("mid_rst_c_rdata", 32'(bus.c_rdata), 32'd0);
    @(negedge clk) reset = 1'b0;
    run_init(1'b1);
    tick();
    bus.c_req = 0;
    tick();
    tick();
    check_eq("post_init_rvalid", 32'(bus.c_rvalid), 32'd1);
    check_eq("post_init_rdata", 32'(bus.c_rdata), 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
